uart_tx: RTL

// - UART transmitter: serialises one PAYLOAD_BITS word per frame onto uart_txd.
// - Frame: start (0), data LSB first, optional parity, STOP_BITS stop bits (1).
// - Pairs with the UART receiver at the far end of the link; fed by a valid/ready source.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter and its receiver partner.
//   uart_state_t   : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   cycles_per_bit : clk cycles per serial bit, from clk and line rate, using
//                    integer nanosecond division so both ends agree exactly.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Bit period and clk period are each truncated to whole nanoseconds
    // before dividing, which is what the receiver side assumes as well.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer for the UART transmitter. Counts 0..CYCLES_PER_BIT-1 while
// a frame is in progress and pulses tick on the last cycle of every bit.
// Held at 0 whenever the transmitter is idle, so each frame starts its first
// bit with a full period.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous reset, active-high
//   busy   in  frame in progress; low clears the counter
//   tick   out high on the final cycle of the current bit
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CYCLES_PER_BIT = 10,
    parameter int STOP_BITS      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic tick
);

    localparam int              CW   = $clog2(CYCLES_PER_BIT * STOP_BITS) + 1;
    localparam logic [CW-1:0]   LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cycle_counter;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || !busy) begin
            cycle_counter <= '0;
        end else if (cycle_counter == LAST) begin
            cycle_counter <= '0;
        end else begin
            cycle_counter <= cycle_counter + 1'b1;
        end
    end

    assign tick = busy && (cycle_counter == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts one PAYLOAD_BITS word over a valid/ready handshake
// and serialises it as: start (0), data LSB first, optional even parity,
// STOP_BITS stop bits (1). Every bit lasts CYCLES_PER_BIT clocks.
// Build option:
//   UART_TX_PARITY_EN  defined   -> PARITY state after DATA sends ^data
//                      undefined -> DATA goes straight to STOP
// Ports:
//   clk            in   system clock
//   reset          in   synchronous reset, active-high (aborts any frame)
//   uart_tx_en     in   allows new frames to be accepted
//   uart_tx_valid  in   uart_tx_data is valid
//   uart_tx_ready  out  a word can be accepted this cycle
//   uart_tx_data   in   word to send
//   uart_tx_busy   out  frame in progress
//   uart_txd       out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic                    uart_tx_valid,
    output logic                    uart_tx_ready,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);

    // bit_counter indexes data bits and, in STOP, counts stop bits.
    localparam int             BCW       = $clog2(PAYLOAD_BITS) + 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(PAYLOAD_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_state_t             state, next_state;
    logic [PAYLOAD_BITS-1:0] shift_reg, shift_next;
    logic [BCW-1:0]          bit_counter, bit_counter_next;
    logic                    txd_next;
    logic                    accept;
    logic                    tick;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`endif

    assign uart_tx_ready = (state == IDLE) && uart_tx_en && !reset;
    assign accept        = uart_tx_valid && uart_tx_ready;
    assign uart_tx_busy  = (state != IDLE);

    uart_baud_tick #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .STOP_BITS      (STOP_BITS)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .busy  (uart_tx_busy),
        .tick  (tick)
    );

    // txd_next is the value the line takes after the coming edge, so the
    // registered output changes exactly at each bit boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        next_state       = state;
        shift_next       = shift_reg;
        bit_counter_next = bit_counter;
        txd_next         = uart_txd;

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (accept) begin
                    next_state       = START;
                    shift_next       = uart_tx_data;
                    bit_counter_next = '0;
                    txd_next         = 1'b0;
                end
            end

            START: begin
                if (tick) begin
                    next_state = DATA;
                    txd_next   = shift_reg[0];
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_counter == LAST_BIT) begin
                        bit_counter_next = '0;
`ifdef UART_TX_PARITY_EN
                        next_state = PARITY;
                        txd_next   = parity_bit;
`else
                        next_state = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        shift_next       = shift_reg >> 1;
                        txd_next         = shift_next[0];
                        bit_counter_next = bit_counter + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    next_state = STOP;
                    txd_next   = 1'b1;
                end
            end
`endif

            STOP: begin
                txd_next = 1'b1;
                if (tick) begin
                    if (bit_counter == LAST_STOP) begin
                        next_state       = IDLE;
                        bit_counter_next = '0;
                    end else begin
                        bit_counter_next = bit_counter + 1'b1;
                    end
                end
            end

            default: begin
                next_state = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            // NOTE: the shift register is cleared only for deterministic idle
            // contents; it is reloaded on every accept and needs no reset.
            shift_reg   <= '0;
            bit_counter <= '0;
            uart_txd    <= 1'b1;
        end else begin
            state       <= next_state;
            shift_reg   <= shift_next;
            bit_counter <= bit_counter_next;
            uart_txd    <= txd_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the word as accepted; later data changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^uart_tx_data;
        end
    end
`endif

endmodule
